// File: rtl/alarm_interval_timer_pkg.sv
// rtl/alarm_interval_timer_pkg.sv - shared types and constants for the alarm interval timer
package alarm_timer_pkg;

    // Interval bank indices, shared with the alarm FSM
    localparam logic [1:0] IDX_ARM       = 2'd0;
    localparam logic [1:0] IDX_DRIVER    = 2'd1;
    localparam logic [1:0] IDX_PASSENGER = 2'd2;
    localparam logic [1:0] IDX_ALARM     = 2'd3;

    localparam int NUM_INTERVALS = 4;

    typedef logic [3:0] seconds_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    // Factory interval values in seconds, reused by the FSM and the display
    localparam int unsigned DEFAULT_T_ARM       = 6;
    localparam int unsigned DEFAULT_T_DRIVER    = 8;
    localparam int unsigned DEFAULT_T_PASSENGER = 15;
    localparam int unsigned DEFAULT_T_ALARM     = 10;

    // Counter width for a divide-by-n prescaler; never narrower than one bit
    function automatic int prescaler_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_interval_timer_if.sv
// rtl/alarm_interval_timer_if.sv - request/status bundle between the alarm FSM and the timer
interface alarm_interval_timer_if;
    import alarm_timer_pkg::*;

    logic       start_timer;
    logic [1:0] interval;
    logic       reprogram;
    logic [1:0] time_parameter_selector;
    seconds_t   time_value;
    logic       expired;
    logic       busy;
    seconds_t   seconds_left;
    logic       one_hz_tick;

    modport master (
        output start_timer,
        output interval,
        output reprogram,
        output time_parameter_selector,
        output time_value,
        input  expired,
        input  busy,
        input  seconds_left,
        input  one_hz_tick
    );

    modport slave (
        input  start_timer,
        input  interval,
        input  reprogram,
        input  time_parameter_selector,
        input  time_value,
        output expired,
        output busy,
        output seconds_left,
        output one_hz_tick
    );

endinterface

// File: rtl/alarm_interval_timer_one_hz_divider.sv
// rtl/alarm_interval_timer_one_hz_divider.sv - seconds prescaler with terminal-count strobe
module one_hz_divider
    import alarm_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = prescaler_width(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next prescaler value; tick marks the edge on which the count wraps.
    // A clear on the same edge suppresses the wrap so a restart never
    // inherits a stale second boundary.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == CNT_MAX) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Prescaler register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alarm_interval_timer.sv
// rtl/alarm_interval_timer.sv - programmable countdown timer for the anti-theft alarm FSM
module alarm_interval_timer
    import alarm_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ              = 27_000_000,
    parameter int unsigned T_ARM_DEFAULT       = DEFAULT_T_ARM,
    parameter int unsigned T_DRIVER_DEFAULT    = DEFAULT_T_DRIVER,
    parameter int unsigned T_PASSENGER_DEFAULT = DEFAULT_T_PASSENGER,
    parameter int unsigned T_ALARM_DEFAULT     = DEFAULT_T_ALARM
) (
    input  logic                  clock,
    input  logic                  reset,
    alarm_interval_timer_if.slave bus
);

    state_e                          state_q;
    state_e                          state_d;
    seconds_t [NUM_INTERVALS-1:0]    bank_q;
    seconds_t [NUM_INTERVALS-1:0]    bank_d;
    seconds_t                        secs_q;
    seconds_t                        secs_d;
    logic                            expired_q;
    logic                            expired_d;
    logic                            tick_q;
    logic                            tick_d;

    logic                            wrap;
    seconds_t                        start_value;

    // A write to the entry being started is forwarded so the new value is used
    always_comb begin
        start_value = bank_q[bus.interval];
        if (bus.reprogram && (bus.time_parameter_selector == bus.interval)) begin
            start_value = bus.time_value;
        end
    end

    // Any start, including a restart mid-count, realigns the second boundary
    one_hz_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_divider (
        .clock  (clock),
        .reset  (reset),
        .clear  (bus.start_timer),
        .enable (state_q == ST_COUNT),
        .tick   (wrap)
    );

    // Bank writes: independent of any count in progress
    always_comb begin
        bank_d = bank_q;
        if (bus.reprogram) begin
            bank_d[bus.time_parameter_selector] = bus.time_value;
        end
    end

    // Next state, remaining seconds and strobes; start overrides the final wrap
    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        expired_d = 1'b0;
        tick_d    = wrap;
        if (bus.start_timer) begin
            if (start_value == '0) begin
                state_d   = ST_IDLE;
                secs_d    = '0;
                expired_d = 1'b1;
            end else begin
                state_d = ST_COUNT;
                secs_d  = start_value;
            end
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (wrap) begin
                        if (secs_q <= seconds_t'(1)) begin
                            state_d   = ST_IDLE;
                            secs_d    = '0;
                            expired_d = 1'b1;
                        end else begin
                            secs_d = secs_q - seconds_t'(1);
                        end
                    end
                end
                default: begin
                    secs_d = '0;
                end
            endcase
        end
    end

    // State, bank and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bank_q[0] <= seconds_t'(T_ARM_DEFAULT);
            bank_q[1] <= seconds_t'(T_DRIVER_DEFAULT);
            bank_q[2] <= seconds_t'(T_PASSENGER_DEFAULT);
            bank_q[3] <= seconds_t'(T_ALARM_DEFAULT);
            secs_q    <= '0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            secs_q    <= secs_d;
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.expired      = expired_q;
    assign bus.busy         = (state_q == ST_COUNT);
    assign bus.seconds_left = secs_q;
    assign bus.one_hz_tick  = tick_q;

endmodule

// File: tb/tb_alarm_interval_timer.sv
// tb/tb_alarm_interval_timer.sv - self-checking bench for alarm_interval_timer
module tb_alarm_interval_timer;
    import alarm_timer_pkg::*;

    localparam int CLK = 4;

    logic clock;
    logic reset;
    alarm_interval_timer_if bus ();

    alarm_interval_timer #(
        .CLK_HZ              (CLK),
        .T_ARM_DEFAULT       (6),
        .T_DRIVER_DEFAULT    (8),
        .T_PASSENGER_DEFAULT (15),
        .T_ALARM_DEFAULT     (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a count is a start edge plus a length in seconds
    int bank [4];
    bit m_active;
    int m_t0;
    int m_v;
    int m_n;
    bit m_exp;
    bit m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int e;
        int val;
        m_n++;
        if (reset) begin
            bank     = '{6, 8, 15, 10};
            m_active = 0;
            m_exp    = 0;
            m_tick   = 0;
        end else begin
            m_exp  = 0;
            m_tick = 0;
            if (m_active) begin
                e = m_n - m_t0;
                if ((e % CLK) == 0 && !bus.start_timer) m_tick = 1;
                if (e == m_v * CLK) begin
                    m_active = 0;
                    m_exp    = !bus.start_timer;
                end
            end
            if (bus.start_timer) begin
                if (bus.reprogram && bus.time_parameter_selector == bus.interval)
                    val = int'(bus.time_value);
                else
                    val = bank[bus.interval];
                if (val == 0) begin
                    m_active = 0;
                    m_exp    = 1;
                end else begin
                    m_active = 1;
                    m_t0     = m_n;
                    m_v      = val;
                end
            end
            if (bus.reprogram) bank[bus.time_parameter_selector] = int'(bus.time_value);
        end
    endtask

    task automatic step();
        int exp_secs;
        @(posedge clock);
        model_edge();
        #1;
        exp_secs = m_active ? (m_v - (m_n - m_t0) / CLK) : 0;
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("seconds_left", 32'(bus.seconds_left), 32'(exp_secs));
        chk("expired", 32'(bus.expired), 32'(m_exp));
        chk("one_hz_tick", 32'(bus.one_hz_tick), 32'(m_tick));
        bus.start_timer = 1'b0;
        bus.reprogram   = 1'b0;
        reset           = 1'b0;
    endtask

    task automatic wait_expired(input string tag, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = bus.expired;
        while (!seen && lat < 200) begin
            step();
            lat++;
            seen = bus.expired;
        end
        chk(tag, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
    endtask

    task automatic start_and_wait(input logic [1:0] idx, input string tag, input int exp_lat);
        bus.start_timer = 1'b1;
        bus.interval    = idx;
        step();
        wait_expired(tag, exp_lat);
    endtask

    initial begin
        m_n      = 0;
        m_active = 0;
        bank     = '{6, 8, 15, 10};
        reset    = 1'b1;
        bus.start_timer             = 1'b0;
        bus.interval                = 2'd0;
        bus.reprogram               = 1'b0;
        bus.time_parameter_selector = 2'd0;
        bus.time_value              = 4'd0;
        step();
        reset = 1'b1;
        step();
        step();

        // Defaults: arm delay of 6 s
        start_and_wait(IDX_ARM, "lat_default_arm", 24);
        step();

        // Reprogram then start
        bus.reprogram = 1'b1; bus.time_parameter_selector = IDX_PASSENGER; bus.time_value = 4'd3;
        step();
        start_and_wait(IDX_PASSENGER, "lat_reprog", 12);

        // Reprogram and start on the same edge, from restored defaults
        reset = 1'b1;
        step();
        bus.reprogram = 1'b1; bus.time_parameter_selector = IDX_PASSENGER; bus.time_value = 4'd3;
        start_and_wait(IDX_PASSENGER, "lat_write_through", 12);

        // Zero interval
        bus.reprogram = 1'b1; bus.time_parameter_selector = IDX_DRIVER; bus.time_value = 4'd0;
        step();
        start_and_wait(IDX_DRIVER, "lat_zero", 0);
        step();

        // Restart mid-count
        bus.start_timer = 1'b1; bus.interval = IDX_ALARM;
        step();
        repeat (9) step();
        start_and_wait(IDX_ARM, "lat_restart", 24);

        // Start on the final wrap edge
        bus.start_timer = 1'b1; bus.interval = IDX_ARM;
        step();
        repeat (23) step();
        bus.start_timer = 1'b1; bus.interval = IDX_ARM;
        step();
        chk("final_wrap_no_expired", 32'(bus.expired), 32'd0);
        chk("final_wrap_reload", 32'(bus.seconds_left), 32'd6);
        wait_expired("lat_after_final_wrap", 24);

        // Reset mid-count
        bus.reprogram = 1'b1; bus.time_parameter_selector = IDX_ARM; bus.time_value = 4'd9;
        step();
        bus.start_timer = 1'b1; bus.interval = IDX_ARM;
        step();
        repeat (6) step();
        reset = 1'b1;
        step();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_secs", 32'(bus.seconds_left), 32'd0);
        start_and_wait(IDX_ARM, "lat_after_reset", 24);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) reset = 1'b1;
            if ($urandom_range(24) == 0) begin
                bus.start_timer = 1'b1;
                bus.interval    = 2'($urandom_range(3));
            end
            if ($urandom_range(9) == 0) begin
                bus.reprogram               = 1'b1;
                bus.time_parameter_selector = 2'($urandom_range(3));
                bus.time_value              = 4'($urandom_range(15));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_interval_timer.md
# alarm_interval_timer

Programmable countdown timer that sequences the delay intervals of the anti-theft alarm FSM (arm delay, driver-door delay, passenger-door delay, siren on-time). The FSM requests an interval by index and receives a one-cycle expiry strobe on its `timer_status` input. The block holds a four-entry bank of reprogrammable interval values and a seconds prescaler, and drives a remaining-seconds value for display.

## Interface
Parameters:
- `CLK_HZ`, 27_000_000: clock cycles per one-second tick. Benches use 4.
- `T_ARM_DEFAULT`, 6: reset value of interval 0 (arm delay), in seconds.
- `T_DRIVER_DEFAULT`, 8: reset value of interval 1 (driver delay).
- `T_PASSENGER_DEFAULT`, 15: reset value of interval 2 (passenger delay).
- `T_ALARM_DEFAULT`, 10: reset value of interval 3 (siren on-time).

Ports:
- `clock`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start_timer`  in  1  single-cycle request: load the selected interval and begin counting.
- `interval`  in  2  interval index, sampled with `start_timer`.
- `reprogram`  in  1  single-cycle write strobe for the interval bank.
- `time_parameter_selector`  in  2  bank entry written on `reprogram`.
- `time_value`  in  4  new value in seconds, 0–15.
- `expired`  out  1  one-cycle strobe when the count reaches zero; drives the FSM `timer_status` input.
- `busy`  out  1  high while counting.
- `seconds_left`  out  4  remaining seconds; holds 0 when idle.
- `one_hz_tick`  out  1  prescaler strobe, one cycle per `CLK_HZ` cycles while busy.

## Operation
- **Interval bank:** 4 × 4-bit registers.
  - On `reset`, each register loads its `T_*_DEFAULT` value.
  - When `reprogram` is high at an edge, `bank[time_parameter_selector]` is written with `time_value`.
  - A reprogram does not affect a count already in progress.
- **States:** IDLE, COUNT. All outputs are registered.
- **IDLE, `start_timer` asserted:**
  - Selected value V ≠ 0: `seconds_left` ← V, prescaler cleared to 0, next state COUNT.
  - V = 0: `expired` ← 1 for one cycle, state stays IDLE.
- **COUNT:**
  - The prescaler counts 0 to `CLK_HZ`−1 and wraps. `one_hz_tick` is high for the cycle after each wrap edge.
  - On a wrap edge, `seconds_left` decrements.
  - On the wrap edge where `seconds_left` = 1, the block sets `seconds_left` ← 0 and `expired` ← 1, and next state is IDLE.
- **`start_timer` while in COUNT:** restart with the newly selected interval. The aborted count never produces `expired`.
- **Simultaneous events:**
  - `start_timer` on the same edge as the final wrap: start wins, the count reloads, and `expired` stays 0.
  - `reprogram` and `start_timer` on the same edge, with `time_parameter_selector` = `interval`: the new `time_value` is loaded (write-through).
- **`reset` at any time, including mid-count:**
  - state IDLE
  - bank restored to defaults
  - prescaler 0
  - `expired` = `busy` = `one_hz_tick` = 0
  - `seconds_left` = 0

## Timing
- Reset values: `expired` 0, `busy` 0, `seconds_left` 0, `one_hz_tick` 0.
- Start sampled at edge t with V ≥ 1:
  - `busy` is high from cycle t+1.
  - Decrements occur at edges t + k·`CLK_HZ`, for k = 1..V.
  - `expired` is high for exactly the cycle after edge t + V·`CLK_HZ`. `busy` falls on that same edge.
- Start with V = 0: `expired` is high for the cycle after edge t, and `busy` stays 0.
- Expiry latency is exactly V·`CLK_HZ` cycles, with no drift. The prescaler is cleared on every start.
- Arithmetic:
  - Prescaler width is $clog2(`CLK_HZ`).
  - `seconds_left` is 4-bit, unsigned, and never wraps below 0.

## Structure
- Shared package `alarm_timer_pkg`:
  - interval index constants: `IDX_ARM`=0, `IDX_DRIVER`=1, `IDX_PASSENGER`=2, `IDX_ALARM`=3
  - state enum
  - 4-bit seconds typedef
  - default interval constants, reused by the FSM and the display
- Sub-module `one_hz_divider`:
  - parameter `CLK_HZ`
  - inputs `clock`, `reset`, `clear`, `enable`
  - output `tick`
- Remaining logic (bank, state machine, seconds counter) lives in the top module.

## Test plan
All scenarios use `CLK_HZ`=4.
- **Reset defaults:** after reset, start `interval`=0 → `expired` pulses once after exactly 24 cycles; `busy` is high for the 24 cycles in between, and `seconds_left` steps 6,5,…,1,0.
- **Reprogram then start:** reprogram selector 2 to 3, then start `interval`=2 → `expired` after 12 cycles. Repeat with reprogram and start on the same edge → same result.
- **Zero interval:** reprogram selector 1 to 0, start `interval`=1 → `expired` high in the cycle right after start, `busy` never rises.
- **Restart mid-count:** start `interval`=3 (10 s), re-issue start with `interval`=0 at cycle 10 → no `expired` from the first count; `expired` arrives 24 cycles after the second start.
- **Start on the final wrap edge:** issue start on the final-wrap edge → no `expired` pulse, count reloads.
- **Reset mid-count:** reprogram selector 0 to 9, start it, assert `reset` at cycle 7 → all outputs 0; bank entry 0 is 6 again, so a following start expires after 24 cycles.
